// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mini-MIPS memory responder: FSM encodings,
// the wait-state limit and the memory-mapped output address.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int MAX_WAIT_CYCLES = 15;
  localparam int CNT_W           = $clog2(MAX_WAIT_CYCLES + 1);

  // The output register lives at the top of the address space (all ones).
  function automatic int mmio_adr(input int aw);
    return (1 << aw) - 1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/acknowledge bus between the CPU memory port (master) and the responder (slave).
interface mem_responder_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 8
);
  logic             req;
  logic             we;
  logic [AW-1:0]    adr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             ack;
  logic             busy;

  modport master (output req, we, adr, wdata, input rdata, ack, busy);
  modport slave  (input req, we, adr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous byte RAM with one-cycle registered read.
// The read register only updates on an enabled read, so it holds between accesses.
module mem_array #(
  parameter int WIDTH = 8,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    adr,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[adr] <= wd;
      end else begin
        rd <= mem[adr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder with programmable wait states. Define MMIO_OUT_EN to map the
// all-ones address onto the io_out register instead of RAM.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus,
  output logic [WIDTH-1:0] io_out
);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [AW-1:0]    adr_q;
  logic             we_q;
  logic [WIDTH-1:0] wd_q;
  logic             ack_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] rdata_reg;
  logic             from_ram_reg;
  logic [WIDTH-1:0] ram_rd;

  logic             commit;
  logic [AW-1:0]    acc_adr;
  logic             acc_we;
  logic [WIDTH-1:0] acc_wd;
  logic             acc_mmio;
  logic             ram_en;

  // With zero wait states the access commits on the accepting edge, so the
  // live bus values stand in for the not-yet-captured ones.
  always_comb begin
    acc_adr = adr_q;
    acc_we  = we_q;
    acc_wd  = wd_q;
    if (state_reg == IDLE) begin
      acc_adr = bus.adr;
      acc_we  = bus.we;
      acc_wd  = bus.wdata;
    end
    commit = !reset &&
             (((state_reg == IDLE) && bus.req && (WAIT_CYCLES == 0)) ||
              ((state_reg == WAIT) && (cnt_reg == '0)));
  end

`ifdef MMIO_OUT_EN
  logic [WIDTH-1:0] io_reg;

  assign acc_mmio = (acc_adr == AW'(mmio_adr(AW)));

  always_ff @(posedge clk) begin
    if (reset) begin
      io_reg <= '0;
    end else if (commit && acc_we && acc_mmio) begin
      io_reg <= acc_wd;
    end
  end

  assign io_out = io_reg;
`else
  assign acc_mmio = 1'b0;
  assign io_out   = '0;
`endif

  assign ram_en = commit && !acc_mmio;

  mem_array #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk (clk),
    .en  (ram_en),
    .we  (acc_we),
    .adr (acc_adr),
    .wd  (acc_wd),
    .rd  (ram_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      adr_q        <= '0;
      we_q         <= 1'b0;
      wd_q         <= '0;
      ack_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      rdata_reg    <= '0;
      from_ram_reg <= 1'b0;
    end else begin
      ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req) begin
            adr_q    <= bus.adr;
            we_q     <= bus.we;
            wd_q     <= bus.wdata;
            busy_reg <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_reg <= RESP;
              ack_reg   <= 1'b1;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= RESP;
            ack_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase

      // Writes and MMIO reads are answered from rdata_reg; RAM reads from the array port.
      if (commit) begin
        if (acc_we) begin
          rdata_reg    <= acc_wd;
          from_ram_reg <= 1'b0;
        end else if (acc_mmio) begin
          rdata_reg    <= io_out;
          from_ram_reg <= 1'b0;
        end else begin
          from_ram_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.rdata = from_ram_reg ? ram_rd : rdata_reg;
  assign bus.ack   = ack_reg;
  assign bus.busy  = busy_reg;

endmodule
